// File: rtl/parity_serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : parity_serial_tx
// Brief    : Accepts one byte per handshake and sends an 11-bit frame
//            (start, 8 data LSB first, parity, stop) on a single line.
// Revision : 1.0 - initial release
// ============================================================================
module parity_serial_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter bit ODD_PARITY   = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       tx,
    output logic       busy,
    output logic       parity,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam logic [7:0] C_DIV_MAX = 8'(CLKS_PER_BIT - 1);

    state_t     r_state, w_state_next;
    logic [7:0] r_div, w_div_next;
    logic [2:0] r_bit, w_bit_next;
    logic [7:0] r_shift, w_shift_next;
    logic       r_parity, w_parity_next;
    logic       r_tx, w_tx_next;
    logic       r_done, w_done_next;
    logic       r_ready, r_busy;
    logic       w_bit_end;

    assign w_bit_end = (r_div == C_DIV_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_div    <= 8'd0;
            r_bit    <= 3'd0;
            r_shift  <= 8'd0;
            r_parity <= 1'b0;
            r_tx     <= 1'b1;
            r_done   <= 1'b0;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_div    <= w_div_next;
            r_bit    <= w_bit_next;
            r_shift  <= w_shift_next;
            r_parity <= w_parity_next;
            r_tx     <= w_tx_next;
            r_done   <= w_done_next;
            r_ready  <= (w_state_next == S_IDLE);
            r_busy   <= (w_state_next != S_IDLE);
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_div_next    = r_div;
        w_bit_next    = r_bit;
        w_shift_next  = r_shift;
        w_parity_next = r_parity;

        case (r_state)
            S_IDLE: begin
                // The shift register only loads on accept, so an X on an
                // idle bus never reaches tx or parity.
                if (in_valid) begin
                    w_state_next  = S_START;
                    w_div_next    = 8'd0;
                    w_shift_next  = in_data;
                    w_parity_next = (^in_data) ^ ODD_PARITY;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_next = S_DATA;
                    w_div_next   = 8'd0;
                    w_bit_next   = 3'd0;
                end else begin
                    w_div_next = r_div + 8'd1;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_div_next = 8'd0;
                    if (r_bit == 3'd7) begin
                        w_state_next = S_PARITY;
                        w_bit_next   = 3'd0;
                    end else begin
                        w_bit_next   = r_bit + 3'd1;
                        w_shift_next = {1'b0, r_shift[7:1]};
                    end
                end else begin
                    w_div_next = r_div + 8'd1;
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_next = S_STOP;
                    w_div_next   = 8'd0;
                end else begin
                    w_div_next = r_div + 8'd1;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_state_next = S_IDLE;
                    w_div_next   = 8'd0;
                end else begin
                    w_div_next = r_div + 8'd1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_div_next   = 8'd0;
                w_bit_next   = 3'd0;
            end
        endcase

        // Line level is decoded from the upcoming state so tx stays registered.
        case (w_state_next)
            S_START:  w_tx_next = 1'b0;
            S_DATA:   w_tx_next = w_shift_next[0];
            S_PARITY: w_tx_next = w_parity_next;
            default:  w_tx_next = 1'b1;
        endcase

        w_done_next = (w_state_next == S_STOP) && (w_div_next == C_DIV_MAX);
    end

    assign in_ready = r_ready;
    assign busy     = r_busy;
    assign tx       = r_tx;
    assign parity   = r_parity;
    assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_parity_serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_parity_serial_tx
// Brief    : Scoreboard bench for parity_serial_tx; three instances cover
//            C=4 even, C=1 odd and C=2 even configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_parity_serial_tx;

    logic       clk;
    logic       reset;
    logic       in_valid [3];
    logic [7:0] in_data  [3];
    logic       in_ready [3];
    logic       tx       [3];
    logic       busy     [3];
    logic       parity   [3];
    logic       done     [3];

    int checks;
    int errors;
    int cyc;

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [8:0] q2[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input int k, input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d t=%0t got %b want %b", name, k, $time, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s t=%0t got %0d want %0d", name, $time, act, exp);
        end
    endtask

    task automatic push_exp(input int k, input logic [8:0] e);
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic pop_exp(input int k, output logic [8:0] e, output bit ok);
        ok = 1'b1;
        e  = '0;
        case (k)
            0:       if (q0.size() > 0) e = q0.pop_front(); else ok = 1'b0;
            1:       if (q1.size() > 0) e = q1.pop_front(); else ok = 1'b0;
            default: if (q2.size() > 0) e = q2.pop_front(); else ok = 1'b0;
        endcase
    endtask

    // Offer a byte, wait (bounded) for the accept edge, record expectation.
    task automatic send(input int k, input logic [7:0] b, input logic p,
                        input bit hold, output int t_acc);
        int w;
        in_valid[k] = 1'b1;
        in_data[k]  = b;
        w = 0;
        @(negedge clk);
        while (in_ready[k] !== 1'b1 && w < 1000) begin
            @(negedge clk);
            w++;
        end
        if (in_ready[k] !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout inst%0d byte %h got in_ready %b want 1", k, b, in_ready[k]);
            in_valid[k] = 1'b0;
            t_acc = -1;
            return;
        end
        @(posedge clk);
        #1;
        t_acc = cyc;
        push_exp(k, {p, b});
        if (!hold) begin
            in_valid[k] = 1'b0;
            in_data[k]  = 8'bx;
        end
    endtask

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int C   = (k == 0) ? 4 : ((k == 1) ? 1 : 2);
        localparam bit ODD = (k == 1);

        parity_serial_tx #(
            .CLKS_PER_BIT(C),
            .ODD_PARITY  (ODD)
        ) u_dut (
            .clk     (clk),
            .reset   (reset),
            .in_valid(in_valid[k]),
            .in_data (in_data[k]),
            .in_ready(in_ready[k]),
            .tx      (tx[k]),
            .busy    (busy[k]),
            .parity  (parity[k]),
            .done    (done[k])
        );

        // Monitor: follows each frame cycle by cycle against the scoreboard.
        initial begin
            int         n;
            bit         act;
            bit         ok;
            logic [8:0] e;
            logic [10:0] frm;
            logic       lp;
            act = 1'b0;
            n   = 0;
            lp  = 1'b0;
            frm = '1;
            forever begin
                @(negedge clk);
                if (reset === 1'b1) begin
                    act = 1'b0;
                    lp  = 1'b0;
                    continue;
                end
                if (!act && busy[k] === 1'b1) begin
                    pop_exp(k, e, ok);
                    if (!ok) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame inst%0d t=%0t got busy 1 want 0", k, $time);
                    end
                    frm = {1'b1, e[8], e[7:0], 1'b0};
                    lp  = e[8];
                    act = 1'b1;
                    n   = 0;
                end
                if (act) begin
                    chk(k, "tx_bit",   tx[k],       frm[n / C]);
                    chk(k, "done",     done[k],     (n == 11 * C - 1));
                    chk(k, "busy",     busy[k],     1'b1);
                    chk(k, "in_ready", in_ready[k], 1'b0);
                    chk(k, "parity",   parity[k],   lp);
                    n++;
                    if (n == 11 * C) act = 1'b0;
                end else begin
                    chk(k, "idle_tx",       tx[k],       1'b1);
                    chk(k, "idle_done",     done[k],     1'b0);
                    chk(k, "idle_busy",     busy[k],     1'b0);
                    chk(k, "idle_in_ready", in_ready[k], 1'b1);
                    chk(k, "idle_parity",   parity[k],   lp);
                end
            end
        end
    end

    initial begin
        int t1;
        int t2;
        logic [7:0] b;
        checks = 0;
        errors = 0;
        cyc    = 0;
        reset  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid[i] = 1'b0;
            in_data[i]  = 8'h00;
        end
        in_data[0] = 8'bx;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        send(0, 8'hA5, 1'b0, 1'b0, t1);
        send(0, 8'h07, 1'b1, 1'b0, t1);
        send(0, 8'h00, 1'b0, 1'b0, t1);
        send(1, 8'hFF, 1'b1, 1'b0, t1);

        // Back-to-back with in_valid held; data changes during first frame.
        send(0, 8'h3C, 1'b0, 1'b1, t1);
        send(0, 8'hC3, 1'b0, 1'b0, t2);
        chk_int("b2b_spacing", t2 - t1, 45);

        // Abandon a frame mid-DATA with reset at T+20.
        send(0, 8'h55, 1'b0, 1'b0, t1);
        repeat (19) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        send(0, 8'h81, 1'b0, 1'b0, t1);

        for (int i = 0; i < 100; i++) begin
            b = 8'($urandom_range(0, 255));
            send(2, b, ^b, 1'b0, t1);
        end

        repeat (60) @(negedge clk);
        chk_int("q0_drained", q0.size(), 0);
        chk_int("q1_drained", q1.size(), 0);
        chk_int("q2_drained", q2.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/parity_serial_tx.md
Name: parity_serial_tx

Overview:
Downstream consumer of the 8-bit even-parity reduction stage. Accepts one byte per handshake, computes its parity bit (XOR-reduction of the byte, optionally inverted), and serialises a fixed 11-bit frame onto one line: start, 8 data bits LSB first, parity, stop. Sits between the byte-producing datapath and the off-block serial link.

Parameters:
CLKS_PER_BIT, 4, clock cycles each frame bit is held on tx; legal range 1..255.
ODD_PARITY, 0, 0 = even parity (parity bit = ^data); 1 = odd parity (parity bit = ~^data).

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous active-high reset
in_valid  input  1  in_data is valid this cycle
in_data  input  8  byte to transmit
in_ready  output  1  block can accept a byte this cycle
tx  output  1  serial line; idles high
busy  output  1  a frame is in progress
parity  output  1  parity bit of the most recently accepted byte; held until the next accept
done  output  1  one-cycle pulse on the last cycle of the stop bit

Behaviour:
- Reset values (cycle after reset is sampled high): tx=1, busy=0, in_ready=1, done=0, parity=0, state=IDLE, bit counter=0, clock-divider counter=0.
- States:
  - IDLE: accept when in_valid && in_ready; latch in_data into a shift register; compute and register parity; go to START. in_valid is ignored in every other state.
  - START, DATA, PARITY, STOP: each bit is held on tx for exactly CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, driven from the shift register.
  - After the STOP bit completes, return to IDLE.
- in_ready = (state==IDLE). busy = (state!=IDLE). Both are registered and mutually exclusive.
- Timing, with the accept at clock edge T and C = CLKS_PER_BIT:
  - tx=0 for cycles T+1..T+C.
  - Data bit i (i=0..7) on cycles T+1+C(i+1)..T+C(i+2).
  - Parity bit on T+1+9C..T+10C.
  - Stop bit (tx=1) on T+1+10C..T+11C.
  - done=1 only on cycle T+11C.
  - in_ready=1 from T+11C+1.
  - Frame occupies 11C cycles. Minimum accept-to-accept spacing is 11C+1 cycles.
- tx is driven from a register, so there is no combinational path from in_data to tx.
- parity output updates on the accept edge and equals (^in_data) XOR ODD_PARITY. The same value is sent in the PARITY slot.
- Changes to in_data or in_valid after the accept do not affect the frame in flight.
- Reset mid-frame: the frame is abandoned. tx=1, state=IDLE and all other outputs take their reset values on the next cycle. No done pulse.
- Reset and in_valid in the same cycle: reset wins; the byte is not accepted.
- Counters: divider counts 0..C-1 and wraps. Bit counter counts 0..7 in DATA and wraps to 0 on entry to PARITY.
- X on in_data while in IDLE with in_valid=0 must not propagate to tx or parity.

Test Plan:
- Even parity, C=4: accept 0xA5 at T → tx pattern start 0, data 1,0,1,0,0,1,0,1, parity 0, stop 1, each bit held 4 cycles; parity=0; done only at T+44; in_ready back at T+45.
- Even parity, C=4: bytes 0x07 then 0x00 → parity outputs 1 then 0; the transmitted parity slot matches each value.
- ODD_PARITY=1, C=1: byte 0xFF → parity=1; tx over 11 cycles = 0,1,1,1,1,1,1,1,1,1,1.
- Back-to-back with in_valid held high and bytes 0x3C then 0xC3 (C=4) → second accept exactly at T+45; in_data changes during the first frame do not alter its bits.
- Reset asserted at T+20 during the DATA state → tx=1, busy=0, in_ready=1, done never pulses; a following byte 0x81 transmits cleanly with parity=0.
- Random 100-byte soak (C=2, even parity) → the decoded frame equals each input byte, the parity slot equals the XOR-reduction, and there are no mismatches.
